// File: rtl/lockstep_fifo.sv
// Multi-channel FWFT FIFO: CHANNELS samples per entry move together under one wr_en/rd_en.
// Latency: push on edge t is visible at dout in cycle t+1; flags are registered from next-state count.
// Backpressure: push dropped while full, pop dropped while empty; LOCKSTEP_FIFO_ERR_EN adds sticky ovf/unf flags.
module lockstep_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] din,
  output logic                           full,
  output logic                           almost_full,
  input  logic                           rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] dout,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           ovf_err,
  output logic                           unf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CHANNELS * DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // full/empty are the registered pre-edge view, so a write at full is rejected even if a pop frees a slot
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(AFULL_THRESH));
    end
  end

  // Storage carries no reset; stale contents stay hidden because dout is zeroed while empty
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

`ifdef LOCKSTEP_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf_err <= 1'b1;
      end
      if (rd_en && empty) begin
        unf_err <= 1'b1;
      end
    end
  end
`else
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif

endmodule
